// File: rtl/if_id_inject_pkg.sv
// Shared processor constants: NOP encoding, two-word opcode detection,
// IF/ID state encoding and the RTI micro-op words issued by rti_fsm.
package if_id_inject_pkg;

    localparam logic [15:0] NOP_WORD       = 16'h0000;
    localparam logic [15:0] IMM_MASK_DEF   = 16'hE000;
    localparam logic [15:0] IMM_MATCH_DEF  = 16'hE000;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_IMM_WAIT = 2'b01,
        ST_INJECT   = 2'b10
    } ifid_state_e;

    // Micro-ops rti_fsm feeds into decode while it restores context on RTI.
    localparam logic [15:0] RTI_UOP_POP_PC_LO = 16'b0110000010001001;
    localparam logic [15:0] RTI_UOP_POP_PC_HI = 16'b0110000010001000;
    localparam logic [15:0] RTI_UOP_POP_FLAGS = 16'b0110000010001010;
    localparam int unsigned RTI_UOP_COUNT     = 3;

    function automatic logic is_two_word(
        input logic [15:0] instr,
        input logic [15:0] mask,
        input logic [15:0] match
    );
        return (instr & mask) == match;
    endfunction

endpackage

// File: rtl/if_id_inject_reg.sv
// IF/ID pipeline register: muxes fetched vs. injected words, assembles
// opcode+immediate pairs, applies flush/stall and drives pc_hold to fetch.
module if_id_inject_reg
    import if_id_inject_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter logic [15:0] IMM_MASK  = IMM_MASK_DEF,
    parameter logic [15:0] IMM_MATCH = IMM_MATCH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     fetch_instr,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [15:0]     inj_instr,
    input  logic            inj_stall,
    input  logic            hazard_stall,
    input  logic            flush,
    output logic [15:0]     id_instr,
    output logic [15:0]     id_imm,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic            inj_active,
    output logic            pc_hold
);

    ifid_state_e     state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            inj_q, inj_d;
    logic [15:0]     held_instr_q, held_instr_d;
    logic [PC_W-1:0] held_pc_q, held_pc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_NORMAL;
            instr_q      <= NOP_WORD;
            imm_q        <= 16'h0000;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            inj_q        <= 1'b0;
            held_instr_q <= NOP_WORD;
            held_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            inj_q        <= inj_d;
            held_instr_q <= held_instr_d;
            held_pc_q    <= held_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        inj_d        = inj_q;
        held_instr_d = held_instr_q;
        held_pc_d    = held_pc_q;

        if (flush) begin
            state_d      = ST_NORMAL;
            instr_d      = NOP_WORD;
            imm_d        = 16'h0000;
            valid_d      = 1'b0;
            inj_d        = 1'b0;
            held_instr_d = NOP_WORD;
            held_pc_d    = '0;
        end else if (inj_stall) begin
            // Injected words bypass two-word detection; any held opcode is lost.
            state_d      = ST_INJECT;
            instr_d      = inj_instr;
            imm_d        = 16'h0000;
            valid_d      = (inj_instr != NOP_WORD);
            inj_d        = 1'b1;
            held_instr_d = NOP_WORD;
            held_pc_d    = '0;
        end else if (hazard_stall) begin
            // Everything holds; the fetched word stays on the bus for next time.
        end else begin
            inj_d = 1'b0;
            if (state_q == ST_IMM_WAIT) begin
                state_d = ST_NORMAL;
                instr_d = held_instr_q;
                pc_d    = held_pc_q;
                imm_d   = fetch_instr;
                valid_d = 1'b1;
            end else if (is_two_word(fetch_instr, IMM_MASK, IMM_MATCH)) begin
                state_d      = ST_IMM_WAIT;
                held_instr_d = fetch_instr;
                held_pc_d    = fetch_pc;
                instr_d      = NOP_WORD;
                imm_d        = 16'h0000;
                valid_d      = 1'b0;
            end else begin
                state_d = ST_NORMAL;
                instr_d = fetch_instr;
                pc_d    = fetch_pc;
                imm_d   = 16'h0000;
                valid_d = 1'b1;
            end
        end
    end

    assign pc_hold    = !flush && (inj_stall || hazard_stall);
    assign id_instr   = instr_q;
    assign id_imm     = imm_q;
    assign id_pc      = pc_q;
    assign id_valid   = valid_q;
    assign inj_active = inj_q;

endmodule

// File: tb/tb_if_id_inject_reg.sv
// Directed bench for if_id_inject_reg: one task per scenario, inline checks.
module tb_if_id_inject_reg;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     fetch_instr;
    logic [PC_W-1:0] fetch_pc;
    logic [15:0]     inj_instr;
    logic            inj_stall;
    logic            hazard_stall;
    logic            flush;
    logic [15:0]     id_instr;
    logic [15:0]     id_imm;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
    logic            inj_active;
    logic            pc_hold;

    int errors = 0;
    int checks = 0;

    if_id_inject_reg #(.PC_W(PC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .inj_instr    (inj_instr),
        .inj_stall    (inj_stall),
        .hazard_stall (hazard_stall),
        .flush        (flush),
        .id_instr     (id_instr),
        .id_imm       (id_imm),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .inj_active   (inj_active),
        .pc_hold      (pc_hold)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_instr = 16'h0; fetch_pc = '0; inj_instr = 16'h0;
        inj_stall = 1'b0; hazard_stall = 1'b0; flush = 1'b0;
        step();
        step();
        checks++;
        if ({id_instr, id_imm, id_pc, id_valid, inj_active} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: instr=%h imm=%h pc=%h valid=%b inj=%b expected all 0",
                     id_instr, id_imm, id_pc, id_valid, inj_active);
        end
        reset = 1'b1;
        $display("reset: outputs instr=%h valid=%b", id_instr, id_valid);
    endtask

    task automatic test_single_word();
        fetch_instr = 16'h1234; fetch_pc = 32'h10;
        #1;
        checks++;
        if (pc_hold !== 1'b0) begin
            errors++; $display("FAIL single_pc_hold: got %b expected 0", pc_hold);
        end
        step();
        checks++;
        if (id_instr !== 16'h1234 || id_pc !== 32'h10 || id_valid !== 1'b1 || id_imm !== 16'h0) begin
            errors++;
            $display("FAIL single_word: instr=%h pc=%h valid=%b imm=%h expected 1234/10/1/0",
                     id_instr, id_pc, id_valid, id_imm);
        end
        $display("single: instr=%h pc=%h valid=%b", id_instr, id_pc, id_valid);
    endtask

    task automatic test_two_word();
        fetch_instr = 16'hE005; fetch_pc = 32'h20;
        step();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 16'h0) begin
            errors++;
            $display("FAIL two_word_bubble: instr=%h valid=%b expected 0000/0", id_instr, id_valid);
        end
        fetch_instr = 16'h00FF; fetch_pc = 32'h22;
        step();
        checks++;
        if (id_instr !== 16'hE005 || id_imm !== 16'h00FF || id_pc !== 32'h20 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL two_word_pair: instr=%h imm=%h pc=%h valid=%b expected E005/00FF/20/1",
                     id_instr, id_imm, id_pc, id_valid);
        end
        $display("two_word: instr=%h imm=%h pc=%h", id_instr, id_imm, id_pc);
    endtask

    task automatic test_inject();
        logic [15:0] words [7];
        logic        vexp  [7];
        words = '{16'b0110000010001001, 16'b0110000010001000, 16'b0110000010001010,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vexp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        fetch_instr = 16'h1111; fetch_pc = 32'h24;
        for (int i = 0; i < 7; i++) begin
            inj_instr = words[i]; inj_stall = 1'b1;
            #1;
            checks++;
            if (pc_hold !== 1'b1) begin
                errors++; $display("FAIL inject_pc_hold[%0d]: got %b expected 1", i, pc_hold);
            end
            step();
            checks++;
            if (id_instr !== words[i] || id_valid !== vexp[i] || inj_active !== 1'b1 ||
                id_pc !== 32'h20 || id_imm !== 16'h0) begin
                errors++;
                $display("FAIL inject[%0d]: instr=%h valid=%b inj=%b pc=%h imm=%h expected %h/%b/1/20/0",
                         i, id_instr, id_valid, inj_active, id_pc, id_imm, words[i], vexp[i]);
            end
            $display("inject[%0d]: instr=%h valid=%b inj=%b", i, id_instr, id_valid, inj_active);
        end
        inj_stall = 1'b0; inj_instr = 16'h0; fetch_instr = 16'h2222; fetch_pc = 32'h30;
        step();
        checks++;
        if (id_instr !== 16'h2222 || id_pc !== 32'h30 || id_valid !== 1'b1 || inj_active !== 1'b0) begin
            errors++;
            $display("FAIL inject_resume: instr=%h pc=%h valid=%b inj=%b expected 2222/30/1/0",
                     id_instr, id_pc, id_valid, inj_active);
        end
        $display("inject_resume: instr=%h inj=%b", id_instr, inj_active);
    endtask

    task automatic test_imm_discard();
        fetch_instr = 16'hE001; fetch_pc = 32'h40;
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL discard_bubble: valid=%b expected 0", id_valid);
        end
        inj_stall = 1'b1; inj_instr = 16'b0110000010001001; fetch_instr = 16'h00AA; fetch_pc = 32'h42;
        step();
        checks++;
        if (id_instr !== 16'h6089 || id_imm !== 16'h0 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL discard_inject: instr=%h imm=%h valid=%b expected 6089/0000/1",
                     id_instr, id_imm, id_valid);
        end
        inj_stall = 1'b0; inj_instr = 16'h0; fetch_instr = 16'h3333; fetch_pc = 32'h44;
        step();
        checks++;
        if (id_instr !== 16'h3333 || id_imm !== 16'h0 || id_pc !== 32'h44 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL discard_resume: instr=%h imm=%h pc=%h valid=%b expected 3333/0000/44/1",
                     id_instr, id_imm, id_pc, id_valid);
        end
        $display("imm_discard: instr=%h imm=%h", id_instr, id_imm);
    endtask

    task automatic test_hazard();
        fetch_instr = 16'h1234; fetch_pc = 32'h50;
        step();
        hazard_stall = 1'b1; fetch_instr = 16'h5555; fetch_pc = 32'h52;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (pc_hold !== 1'b1) begin
                errors++; $display("FAIL hazard_pc_hold[%0d]: got %b expected 1", i, pc_hold);
            end
            step();
            checks++;
            if (id_instr !== 16'h1234 || id_pc !== 32'h50 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL hazard_hold[%0d]: instr=%h pc=%h valid=%b expected 1234/50/1",
                         i, id_instr, id_pc, id_valid);
            end
            $display("hazard[%0d]: instr=%h pc_hold=%b", i, id_instr, pc_hold);
        end
        hazard_stall = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1; inj_stall = 1'b1; inj_instr = 16'h6088;
        #1;
        checks++;
        if (pc_hold !== 1'b0) begin
            errors++; $display("FAIL flush_pc_hold: got %b expected 0", pc_hold);
        end
        step();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 16'h0 || inj_active !== 1'b0) begin
            errors++;
            $display("FAIL flush_inject: instr=%h valid=%b inj=%b expected 0000/0/0",
                     id_instr, id_valid, inj_active);
        end
        flush = 1'b0; inj_stall = 1'b0; inj_instr = 16'h0;
        // Flush while an opcode is held: its immediate must not be paired.
        fetch_instr = 16'hE007; fetch_pc = 32'h60;
        step();
        flush = 1'b1; fetch_instr = 16'h00BB; fetch_pc = 32'h62;
        step();
        flush = 1'b0; fetch_instr = 16'h4444; fetch_pc = 32'h70;
        step();
        checks++;
        if (id_instr !== 16'h4444 || id_imm !== 16'h0 || id_pc !== 32'h70 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_imm_wait: instr=%h imm=%h pc=%h valid=%b expected 4444/0000/70/1",
                     id_instr, id_imm, id_pc, id_valid);
        end
        $display("flush: instr=%h valid=%b", id_instr, id_valid);
    endtask

    task automatic test_async_reset();
        inj_stall = 1'b1; inj_instr = 16'h6089;
        step();
        checks++;
        if (inj_active !== 1'b1) begin
            errors++; $display("FAIL async_pre: inj=%b expected 1", inj_active);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({id_instr, id_imm, id_pc, id_valid, inj_active} !== '0) begin
            errors++;
            $display("FAIL async_reset: instr=%h imm=%h pc=%h valid=%b inj=%b expected all 0",
                     id_instr, id_imm, id_pc, id_valid, inj_active);
        end
        $display("async_reset: instr=%h inj=%b", id_instr, inj_active);
        inj_stall = 1'b0; inj_instr = 16'h0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_word();
        test_inject();
        test_imm_discard();
        test_hazard();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
